// File: rtl/mcpu_mem_ltc_pkg.sv
// Shared constants and types for the LTC line-data BRAM sharing controller.
package mcpu_mem_ltc_pkg;

  localparam int LTC_NREQ        = 2;
  localparam int LTC_DEPTH_BITS  = 9;
  localparam int LTC_WIDTH_BYTES = 32;
  localparam int LTC_LINE_BITS   = LTC_WIDTH_BYTES * 8;

  // Requester slots on the arbiter.
  localparam int LTC_REQ_CORE = 0;
  localparam int LTC_REQ_FILL = 1;

  localparam logic [15:0] LTC_CNT_MAX = 16'hFFFF;

  typedef logic [LTC_LINE_BITS-1:0]   ltc_line_t;
  typedef logic [LTC_WIDTH_BYTES-1:0] ltc_be_t;
  typedef logic [LTC_DEPTH_BITS-1:0]  ltc_addr_t;

endpackage

// File: rtl/mcpu_mem_ltc_rr_pick.sv
// Combinational rotate-priority picker: the first requester at or after ptr
// (wrapping modulo N) wins. Pointer state lives in the parent.
module mcpu_mem_ltc_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  int  cand;
  logic found;

  // Scan N slots starting at the pointer; the first asserted request wins.
  always_comb begin
    // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mcpu_mem_ltc_arb.sv
// LTC line-data BRAM sharing controller: one write and one read grant per
// cycle from independent round-robin arbiters, with a same-address hazard
// that defers the read behind the write.
module mcpu_mem_ltc_arb
  import mcpu_mem_ltc_pkg::*;
#(
  parameter int NREQ        = LTC_NREQ,
  parameter int DEPTH_BITS  = LTC_DEPTH_BITS,
  parameter int WIDTH_BYTES = LTC_WIDTH_BYTES
) (
  input  logic                            clkrst_mem_clk,
  input  logic                            clkrst_mem_rst,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ-1:0]                 req_we,
  input  logic [NREQ*DEPTH_BITS-1:0]      req_addr,
  input  logic [NREQ*WIDTH_BYTES-1:0]     req_wbe,
  input  logic [NREQ*WIDTH_BYTES*8-1:0]   req_wdata,
  output logic [NREQ-1:0]                 resp_valid,
  output logic [WIDTH_BYTES*8-1:0]        resp_rdata,
  output logic [DEPTH_BITS-1:0]           bram_waddr,
  output logic [WIDTH_BYTES-1:0]          bram_wbe,
  output logic [WIDTH_BYTES*8-1:0]        bram_wdata,
  output logic                            bram_re,
  output logic [DEPTH_BITS-1:0]           bram_raddr,
  input  logic [WIDTH_BYTES*8-1:0]        bram_rdata,
  output logic [15:0]                     conflict_cnt
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int LW    = WIDTH_BYTES * 8;

  logic [PTR_W-1:0] wptr, rptr;
  logic [NREQ-1:0]  wr_cand, rd_cand;
  logic [NREQ-1:0]  w_gnt, r_gnt;
  logic [PTR_W-1:0] w_idx, r_idx;
  logic             w_any, r_any;
  logic             hazard, wr_grant, rd_grant;
  logic [DEPTH_BITS-1:0] w_addr, r_addr;

  assign wr_cand = req_valid & req_we;
  assign rd_cand = req_valid & ~req_we;

  mcpu_mem_ltc_rr_pick #(.N(NREQ), .PTR_W(PTR_W)) u_wr_pick (
    .req (wr_cand),
    .ptr (wptr),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  mcpu_mem_ltc_rr_pick #(.N(NREQ), .PTR_W(PTR_W)) u_rd_pick (
    .req (rd_cand),
    .ptr (rptr),
    .gnt (r_gnt),
    .idx (r_idx)
  );

  assign w_any  = |w_gnt;
  assign r_any  = |r_gnt;
  assign w_addr = req_addr[int'(w_idx)*DEPTH_BITS +: DEPTH_BITS];
  assign r_addr = req_addr[int'(r_idx)*DEPTH_BITS +: DEPTH_BITS];

  // A read to the line being written this cycle waits one cycle so it
  // returns the post-write contents.
  assign hazard   = w_any && r_any && (w_addr == r_addr);
  assign wr_grant = w_any && !clkrst_mem_rst;
  assign rd_grant = r_any && !hazard && !clkrst_mem_rst;

  // Drive handshake and BRAM ports from the two winners; reset masks all strobes.
  always_comb begin
    req_ready  = (wr_grant ? w_gnt : '0) | (rd_grant ? r_gnt : '0);
    bram_waddr = w_addr;
    bram_wdata = req_wdata[int'(w_idx)*LW +: LW];
    bram_wbe   = wr_grant ? req_wbe[int'(w_idx)*WIDTH_BYTES +: WIDTH_BYTES] : '0;
    bram_re    = rd_grant;
    bram_raddr = r_addr;
  end

  // Registered read port data is returned untouched; resp_valid qualifies it.
  assign resp_rdata = bram_rdata;

  // Pointer advance, response valid pipeline and hazard counter.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      wptr         <= '0;
      rptr         <= '0;
      resp_valid   <= '0;
      conflict_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (wr_grant) begin
        wptr <= (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (rd_grant) begin
        rptr <= (r_idx == PTR_W'(NREQ - 1)) ? '0 : r_idx + 1'b1;
      end
      resp_valid <= rd_grant ? r_gnt : '0;
      if (hazard && (conflict_cnt != LTC_CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_mem_ltc_arb.sv
// Self-checking bench for mcpu_mem_ltc_arb: behavioural BRAM, a line-level
// reference memory, and a response scoreboard.
module tb_mcpu_mem_ltc_arb;
  import mcpu_mem_ltc_pkg::*;

  localparam int NR = LTC_NREQ;
  localparam int DB = LTC_DEPTH_BITS;
  localparam int WB = LTC_WIDTH_BYTES;
  localparam int LW = LTC_LINE_BITS;

  typedef struct {
    int        rq;
    ltc_line_t data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_we, resp_valid;
  logic [NR*DB-1:0]  req_addr;
  logic [NR*WB-1:0]  req_wbe;
  logic [NR*LW-1:0]  req_wdata;
  ltc_line_t         resp_rdata, bram_wdata, bram_rdata;
  ltc_addr_t         bram_waddr, bram_raddr;
  ltc_be_t           bram_wbe;
  logic              bram_re;
  logic [15:0]       conflict_cnt;

  ltc_line_t bram      [0:(1<<DB)-1];
  ltc_line_t model_mem [0:(1<<DB)-1];
  exp_t      exp_q[$];
  int        n_cmp = 0;
  int        n_bad = 0;
  logic [NR-1:0] acc;

  mcpu_mem_ltc_arb dut (
    .clkrst_mem_clk (clk),
    .clkrst_mem_rst (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wbe        (req_wbe),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .bram_waddr     (bram_waddr),
    .bram_wbe       (bram_wbe),
    .bram_wdata     (bram_wdata),
    .bram_re        (bram_re),
    .bram_raddr     (bram_raddr),
    .bram_rdata     (bram_rdata),
    .conflict_cnt   (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: byte-enabled write, 1-cycle registered read.
  always @(posedge clk) begin
    for (int b = 0; b < WB; b++)
      if (bram_wbe[b]) bram[bram_waddr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
    if (bram_re) bram_rdata <= bram[bram_raddr];
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ltc_line_t mk_line(input logic [31:0] seed);
    ltc_line_t l;
    for (int j = 0; j < 8; j++) l[j*32 +: 32] = seed + 32'(j) * 32'h0101_0101;
    return l;
  endfunction

  task automatic drive(input int r, input logic we, input ltc_addr_t a,
                       input ltc_be_t be, input ltc_line_t d);
    req_valid[r]          = 1'b1;
    req_we[r]             = we;
    req_addr[r*DB +: DB]  = a;
    req_wbe[r*WB +: WB]   = be;
    req_wdata[r*LW +: LW] = d;
  endtask

  task automatic drop(input int r);
    req_valid[r] = 1'b0;
  endtask

  // Settle, record accepted requests into the model/scoreboard, advance one cycle.
  task automatic run_cycle();
    ltc_addr_t a;
    #1;
    acc = req_ready;
    for (int r = 0; r < NR; r++) begin
      if (req_valid[r] && req_ready[r]) begin
        a = req_addr[r*DB +: DB];
        if (req_we[r]) begin
          for (int b = 0; b < WB; b++)
            if (req_wbe[r*WB + b]) model_mem[a][b*8 +: 8] = req_wdata[r*LW + b*8 +: 8];
        end else begin
          exp_q.push_back('{rq: r, data: model_mem[a]});
        end
      end
    end
    @(negedge clk);
  endtask

  // Response monitor: every resp_valid must match the oldest expected read.
  always @(negedge clk) begin
    exp_t e;
    if ($countones(resp_valid) > 1) check("resp_onehot", LW'($countones(resp_valid)), 1);
    for (int r = 0; r < NR; r++) begin
      if (resp_valid[r]) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", LW'(r + 1), 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_req", LW'(r), LW'(e.rq));
          check("resp_data", resp_rdata, e.data);
        end
      end
    end
  end

  initial begin
    int k0, k1, bad;
    ltc_line_t x;
    for (int i = 0; i < (1<<DB); i++) begin
      bram[i]      = '0;
      model_mem[i] = '0;
    end
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wbe = '0; req_wdata = '0;

    // Reset: strobes forced low while requests are pending.
    drive(0, 1'b1, 9'h001, '1, mk_line(32'h1));
    drive(1, 1'b0, 9'h002, '0, '0);
    #1;
    check("rst_ready", LW'(req_ready), 0);
    check("rst_re", LW'(bram_re), 0);
    check("rst_wbe", LW'(bram_wbe), 0);
    @(negedge clk);
    check("rst_resp_valid", LW'(resp_valid), 0);
    check("rst_conflict", LW'(conflict_cnt), 0);
    drop(0); drop(1);
    @(negedge clk);
    rst = 1'b0;

    // Both requesters write continuously: grants alternate 0,1,0,1.
    k0 = 0; k1 = 0;
    drive(0, 1'b1, 9'h040, '1, mk_line(32'h4000_0000));
    drive(1, 1'b1, 9'h050, '1, mk_line(32'h5000_0000));
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      check("wr_rr_grant", LW'(acc), (c % 2 == 0) ? 2'b01 : 2'b10);
      if (acc[0]) begin
        k0++;
        drive(0, 1'b1, ltc_addr_t'(9'h040 + k0), '1, mk_line(32'h4000_0000 + 32'(k0)));
      end
      if (acc[1]) begin
        k1++;
        drive(1, 1'b1, ltc_addr_t'(9'h050 + k1), '1, mk_line(32'h5000_0000 + 32'(k1)));
      end
    end
    drop(0); drop(1);
    // Back-to-back readback, one read per cycle.
    drive(0, 1'b0, 9'h040, '0, '0); run_cycle(); check("rb_grant", LW'(acc), 2'b01);
    drive(0, 1'b0, 9'h041, '0, '0); run_cycle(); check("rb_grant", LW'(acc), 2'b01);
    drive(0, 1'b0, 9'h050, '0, '0); run_cycle(); check("rb_grant", LW'(acc), 2'b01);
    drive(0, 1'b0, 9'h051, '0, '0); run_cycle(); check("rb_grant", LW'(acc), 2'b01);
    drop(0); run_cycle();

    // Write then read on requester 0.
    drive(0, 1'b1, 9'h010, '1, mk_line(32'hA5A5_0010));
    run_cycle(); check("wr_a_grant", LW'(acc), 2'b01);
    drive(0, 1'b0, 9'h010, '0, '0);
    run_cycle(); check("rd_a_grant", LW'(acc), 2'b01);
    drop(0); run_cycle();

    // Same-address hazard: read deferred, conflict counted, new low bytes seen.
    drive(1, 1'b1, 9'h020, '1, mk_line(32'hB0B0_0020));
    run_cycle(); drop(1);
    drive(0, 1'b0, 9'h020, '0, '0);
    drive(1, 1'b1, 9'h020, 32'h0000_000F, {{(LW-32){1'b0}}, 32'h1122_3344});
    run_cycle(); check("hz_grant", LW'(acc), 2'b10);
    check("hz_bram_re", LW'(bram_re), 0);
    check("hz_conflict", LW'(conflict_cnt), 1);
    drop(1);
    run_cycle(); check("hz_retry_grant", LW'(acc), 2'b01);
    x = mk_line(32'hB0B0_0020); x[31:0] = 32'h1122_3344;
    check("hz_model_merge", model_mem[9'h020], x);
    drop(0); run_cycle();

    // Different addresses: both granted, no conflict.
    drive(0, 1'b0, 9'h030, '0, '0);
    drive(1, 1'b1, 9'h031, '1, mk_line(32'hC0C0_0031));
    run_cycle(); check("diff_grant", LW'(acc), 2'b11);
    check("diff_conflict", LW'(conflict_cnt), 1);
    drop(0); drop(1); run_cycle();

    // Reset right after a read grant; pointers left at 1 beforehand.
    drive(0, 1'b1, 9'h060, '1, mk_line(32'hD0D0_0060));
    run_cycle(); check("pre_rst_wr", LW'(acc), 2'b01);
    drive(0, 1'b0, 9'h010, '0, '0);
    #1; check("pre_rst_rd", LW'(req_ready), 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    drop(0);
    @(negedge clk);
    check("mid_rst_resp_valid", LW'(resp_valid), 0);
    check("mid_rst_conflict", LW'(conflict_cnt), 0);
    rst = 1'b0;
    drive(0, 1'b0, 9'h010, '0, '0);
    drive(1, 1'b0, 9'h060, '0, '0);
    run_cycle(); check("post_rst_rptr", LW'(acc), 2'b01);
    drop(0);
    run_cycle(); check("post_rst_rd1", LW'(acc), 2'b10);
    drop(1);
    drive(0, 1'b1, 9'h070, '1, mk_line(32'hE0E0_0070));
    drive(1, 1'b1, 9'h071, '1, mk_line(32'hE0E0_0071));
    run_cycle(); check("post_rst_wptr", LW'(acc), 2'b01);
    drop(0);
    run_cycle(); check("post_rst_wr1", LW'(acc), 2'b10);
    drop(1); run_cycle();

    // Saturation: repeated zero-byte-enable writes colliding with a read.
    drive(1, 1'b1, 9'h080, '1, mk_line(32'hF0F0_0080));
    run_cycle(); drop(1);
    drive(0, 1'b0, 9'h080, '0, '0);
    drive(1, 1'b1, 9'h080, '0, mk_line(32'hDEAD_BEEF));
    bad = 0;
    for (int i = 0; i < 65540; i++) begin
      run_cycle();
      if (acc !== 2'b10) bad++;
      if (i == 65533) check("sat_cnt_fffe", LW'(conflict_cnt), 16'hFFFE);
    end
    check("sat_grants", LW'(bad), 0);
    check("sat_cnt", LW'(conflict_cnt), 16'hFFFF);
    drop(1);
    run_cycle(); check("sat_release", LW'(acc), 2'b01);
    drop(0); run_cycle(); run_cycle();

    check("resp_outstanding", LW'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
